// File: rtl/mac_cascade_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mac_cascade_loader                                              |
// | Purpose  : Shifts a config image into the MAC serial config chain, then    |
// |            streams W_D*N_UNITS weights into the weight cascade.            |
// | Option   : MAC_CFG_READBACK_EN adds a rotate-and-compare verify pass.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mac_cascade_loader #(
    parameter int CFG_LEN = 16,
    parameter int W_W     = 8,
    parameter int W_D     = 4,
    parameter int N_UNITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CFG_LEN-1:0] cfg_word,
    input  logic               w_valid,
    input  logic [W_W-1:0]     w_data,
    output logic               w_ready,
    output logic               config_en,
    output logic               config_in,
    input  logic               config_out,
    output logic [W_W-1:0]     W_in,
    output logic               W_en,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam int W_TOTAL = W_D * N_UNITS;
    localparam int CW      = $clog2(W_TOTAL + 1);
    localparam int BW      = $clog2(CFG_LEN + 1);

    localparam logic [BW-1:0] c_BIT_LAST = BW'(CFG_LEN - 1);
    localparam logic [CW-1:0] c_W_LAST   = CW'(W_TOTAL - 1);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_CFG_SHIFT  = 3'd1;
`ifdef MAC_CFG_READBACK_EN
    localparam logic [2:0] c_CFG_VERIFY = 3'd2;
`endif
    localparam logic [2:0] c_W_LOAD     = 3'd3;
    localparam logic [2:0] c_DONE       = 3'd4;

    logic [2:0]         r_state;
    logic [BW-1:0]      r_bit_cnt;
    logic [CW-1:0]      r_w_cnt;
    logic [CFG_LEN-1:0] r_shift;
    logic               r_config_in;
    logic               r_config_en;
    logic               r_w_ready;
    logic [W_W-1:0]     r_w_in;
    logic               r_w_en;
    logic               r_busy;
    logic               r_done;
`ifdef MAC_CFG_READBACK_EN
    logic [CFG_LEN-1:0] r_cfg;
    logic               r_verify;
    logic               r_cfg_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_bit_cnt   <= '0;
            r_w_cnt     <= '0;
            r_shift     <= '0;
            r_config_in <= 1'b0;
            r_config_en <= 1'b0;
            r_w_ready   <= 1'b0;
            r_w_in      <= '0;
            r_w_en      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef MAC_CFG_READBACK_EN
            r_cfg       <= '0;
            r_verify    <= 1'b0;
            r_cfg_err   <= 1'b0;
`endif
        end else begin
            r_w_en <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_shift     <= cfg_word << 1;
                        r_config_in <= cfg_word[CFG_LEN-1];
                        r_config_en <= 1'b1;
                        r_busy      <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_w_cnt     <= '0;
                        r_state     <= c_CFG_SHIFT;
`ifdef MAC_CFG_READBACK_EN
                        r_cfg       <= cfg_word;
                        r_cfg_err   <= 1'b0;
`endif
                    end
                end
                c_CFG_SHIFT: begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_config_in <= 1'b0;
`ifdef MAC_CFG_READBACK_EN
                        r_bit_cnt   <= '0;
                        r_shift     <= r_cfg;
                        r_verify    <= 1'b1;
                        r_state     <= c_CFG_VERIFY;
`else
                        r_config_en <= 1'b0;
                        r_w_ready   <= 1'b1;
                        r_state     <= c_W_LOAD;
`endif
                    end else begin
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        r_config_in <= r_shift[CFG_LEN-1];
                        r_shift     <= r_shift << 1;
                    end
                end
`ifdef MAC_CFG_READBACK_EN
                c_CFG_VERIFY: begin
                    // The tail presents the image MSB first, same order it went in.
                    if (config_out != r_shift[CFG_LEN-1]) begin
                        r_cfg_err <= 1'b1;
                    end
                    r_shift <= r_shift << 1;
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_verify    <= 1'b0;
                        r_config_en <= 1'b0;
                        r_w_ready   <= 1'b1;
                        r_state     <= c_W_LOAD;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
`endif
                c_W_LOAD: begin
                    if (r_w_ready && w_valid) begin
                        r_w_in  <= w_data;
                        r_w_en  <= 1'b1;
                        r_w_cnt <= r_w_cnt + 1'b1;
                        if (r_w_cnt == c_W_LAST) begin
                            r_w_ready <= 1'b0;
                        end
                    end else if (!r_w_ready) begin
                        // This is the cycle carrying the final W_en pulse.
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign w_ready   = r_w_ready;
    assign config_en = r_config_en;
    assign W_in      = r_w_in;
    assign W_en      = r_w_en;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef MAC_CFG_READBACK_EN
    // Rotate: the tail bit is fed straight back into the head during verify.
    assign config_in = r_verify ? config_out : r_config_in;
    assign cfg_err   = r_cfg_err;
`else
    logic w_unused_config_out;
    assign w_unused_config_out = config_out;
    assign config_in = r_config_in;
    assign cfg_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_cascade_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mac_cascade_loader                                           |
// | Purpose  : Directed/random checks of mac_cascade_loader against a          |
// |            cycle-level reference model and a config-chain model.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mac_cascade_loader;

    localparam int L  = 16;
    localparam int WW = 8;
    localparam int WT = 16;
`ifdef MAC_CFG_READBACK_EN
    localparam bit RB    = 1'b1;
    localparam int L_EFF = 2 * L;
`else
    localparam bit RB    = 1'b0;
    localparam int L_EFF = L;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [L-1:0]  cfg_word = '0;
    logic          w_valid = 1'b0;
    logic [WW-1:0] w_data = '0;
    logic          w_ready, config_en, config_in, config_out;
    logic [WW-1:0] W_in;
    logic          W_en, busy, done, cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [L-1:0]  chain = '0;
    bit            stuck3 = 1'b0;
    logic [WW-1:0] w_in_model = '0;

    mac_cascade_loader #(
        .CFG_LEN (L),
        .W_W     (WW),
        .W_D     (4),
        .N_UNITS (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_word   (cfg_word),
        .w_valid    (w_valid),
        .w_data     (w_data),
        .w_ready    (w_ready),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .W_in       (W_in),
        .W_en       (W_en),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // Serial config chain: head enters at bit 0, tail is the MSB.
    assign config_out = chain[L-1];
    always @(posedge clk) begin : chain_model
        logic [L-1:0] nxt;
        if (config_en) begin
            nxt = {chain[L-2:0], config_in};
            if (stuck3) nxt[3] = 1'b0;
            chain <= nxt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag, input logic exp_err);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_w_ready"}, w_ready, 0);
        chk({tag, "_config_en"}, config_en, 0);
        chk({tag, "_W_en"}, W_en, 0);
        chk({tag, "_W_in"}, W_in, w_in_model);
        chk({tag, "_cfg_err"}, cfg_err, exp_err);
    endtask

    // mode: 0 = always valid, 1 = alternate 1,0,.. from first load cycle, 2 = random
    task automatic run_load(input logic [L-1:0] cfg, input int mode, input bit seq_words,
                            input bit hold, input int abort_at);
        logic [WW-1:0] words[WT];
        int  c, acc, fin, ld0;
        bit  hs_prev, hs, mism, v, e_wr, e_done, e_busy;
        c = 0; acc = 0; fin = -1; ld0 = L_EFF + 1;
        hs_prev = 0; mism = 0;
        for (int i = 0; i < WT; i++) words[i] = seq_words ? WW'(i + 1) : WW'($urandom);
        cfg_word = cfg;
        start    = 1'b1;
        while (1) begin
            @(negedge clk);
            c++;
            if (!hold) start = 1'b0;
            if (hs_prev) w_in_model = words[acc-1];
            if (hs_prev && acc == WT) fin = c;
            e_wr   = (c >= ld0) && (acc < WT);
            e_done = (fin >= 0) && (c == fin + 1);
            e_busy = !((fin >= 0) && (c >= fin + 1));
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("w_ready", w_ready, e_wr);
            chk("W_en", W_en, hs_prev);
            chk("W_in", W_in, w_in_model);
            chk("config_en", config_en, c <= L_EFF);
            chk("cfg_err", cfg_err, RB ? mism : 1'b0);
            if (c <= L) chk("config_in", config_in, cfg[L-c]);
            if (RB && c > L && c <= 2 * L && config_out !== cfg[2*L-c]) mism = 1'b1;
            if (fin >= 0 && c == fin + 2) break;
            if (c > 1000) begin
                n_tests++; n_fail++;
                $error("FAIL timeout: observed cycle %0d expected done by 1000", c);
                break;
            end
            if (abort_at >= 0 && c >= ld0 && acc == abort_at) begin
                reset = 1'b1; start = 1'b0; w_valid = 1'b0;
                @(negedge clk);
                w_in_model = '0;
                check_quiet("reset_mid", 1'b0);
                chk("reset_mid_config_in", config_in, 0);
                reset = 1'b0;
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (c >= ld0) ? ((c - ld0) % 2 == 0) : 1'b0;
                default: v = ($urandom_range(0, 1) == 1) || (c > ld0 + 200);
            endcase
            w_valid = v;
            w_data  = (v && acc < WT) ? words[acc] : WW'($urandom);
            hs      = e_wr && v;
            if (hs) acc++;
            hs_prev = hs;
        end
        w_valid = 1'b0;
    endtask

    initial begin
        logic [L-1:0] cfg_r;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset", 1'b0);
        chk("reset_config_in", config_in, 0);
        reset = 1'b0;
        @(negedge clk);
        check_quiet("idle", 1'b0);

        run_load(16'hA5C3, 0, 1'b1, 1'b0, -1);
        chk("chain_t1", chain, 16'hA5C3);

        cfg_r = L'($urandom);
        run_load(cfg_r, 1, 1'b0, 1'b0, -1);
        chk("chain_t2", chain, cfg_r);

        cfg_r = L'($urandom);
        run_load(cfg_r, 2, 1'b0, 1'b1, -1);
        cfg_r = L'($urandom);
        run_load(cfg_r, 0, 1'b0, 1'b1, -1);
        start = 1'b0;
        @(negedge clk);
        check_quiet("after_hold", 1'b0);
        chk("chain_t3", chain, cfg_r);

        cfg_r = L'($urandom);
        run_load(cfg_r, 0, 1'b0, 1'b0, 5);
        @(negedge clk);
        check_quiet("post_reset_idle", 1'b0);
        run_load(cfg_r, 2, 1'b0, 1'b0, -1);
        chk("chain_t4", chain, cfg_r);

`ifdef MAC_CFG_READBACK_EN
        run_load(16'hA5C3, 0, 1'b0, 1'b0, -1);
        chk("chain_t5", chain, 16'hA5C3);
        chk("cfg_err_t5", cfg_err, 0);
        stuck3 = 1'b1;
        run_load(16'hA5C3, 2, 1'b0, 1'b0, -1);
        chk("cfg_err_t6", cfg_err, 1);
        @(negedge clk);
        check_quiet("t6_idle", 1'b1);
        stuck3 = 1'b0;
        run_load(16'hA5C3, 0, 1'b0, 1'b0, -1);
        chk("chain_t6", chain, 16'hA5C3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
